// File: rtl/neural_rec_mem.sv
// neural_rec_mem -- capture side of the neural data test harness.
//
// Records one {sample, trigger} word per CLK_ADC cycle into on-chip memory
// until DEPTH words are held, then replays them on a valid/ready stream.
//
// Ports:
//   CLK_ADC     in   single clock (ADC sample clock)
//   RST         in   synchronous reset, active-high, overrides everything
//   EN          in   record enable, one sample captured per cycle while high
//   DATA_IN     in   [DW-1:0] signed sample to record
//   TRGG_IN     in   trigger flag accompanying DATA_IN
//   CLR         in   discard recording, restart capture (beats DUMP_START/EN)
//   DUMP_START  in   start readout from word 0
//   DOUT        out  [DW-1:0] signed readout sample
//   DOUT_TRGG   out  readout trigger flag
//   DOUT_VALID  out  readout word valid
//   DOUT_READY  in   consumer accepts the word
//   DOUT_LAST   out  current readout word is the final recorded word
//   REC_CNT     out  [AW-1:0] number of words recorded
//   TRG_CNT     out  [15:0] recorded samples with trigger set (saturating)
//   REC_FULL    out  REC_CNT == DEPTH
//   BUSY        out  high while dumping
//   DBG_STATE   out  [1:0] FSM state (0 REC, 1 DUMP, 2 DONE)
//
// Readout handshake: a word moves on every CLK_ADC edge where DOUT_VALID and
// DOUT_READY are both high. While DOUT_VALID is high and DOUT_READY is low,
// DOUT, DOUT_TRGG and DOUT_LAST hold stable. DOUT_VALID never drops before
// the word is taken, except by CLR or RST.

module neural_rec_mem #(
  parameter int DEPTH = 5000,
  parameter int AW    = 13,
  parameter int DW    = 12
) (
  input  logic          CLK_ADC,
  input  logic          RST,
  input  logic          EN,
  input  logic [DW-1:0] DATA_IN,
  input  logic          TRGG_IN,
  input  logic          CLR,
  input  logic          DUMP_START,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_TRGG,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic          DOUT_LAST,
  output logic [AW-1:0] REC_CNT,
  output logic [15:0]   TRG_CNT,
  output logic          REC_FULL,
  output logic          BUSY,
  output logic [1:0]    DBG_STATE
);

  // Memory address width; the counters carry AW bits so they can reach DEPTH.
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_REC  = 2'd0,
    S_DUMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rec_cnt_q;
  logic [AW-1:0] rd_ptr_q;
  logic [15:0]   trg_cnt_q;
  logic [DW:0]   dout_q;          // {sample, trigger}
  logic [DW:0]   mem [0:DEPTH-1]; // {sample, trigger}

  logic          full;
  logic          wr_en;
  logic [AW-1:0] cnt_after;
  logic          last;
  logic          xfer;
  logic          start_dump;
  logic [AW-1:0] rd_addr;
  logic [DW:0]   rd_word;
  logic          bypass;

  assign full      = (rec_cnt_q == AW'(DEPTH));
  assign wr_en     = (state_q == S_REC) && EN && !full && !CLR;
  assign cnt_after = rec_cnt_q + {{(AW-1){1'b0}}, wr_en};
  assign last      = (state_q == S_DUMP) && (rd_ptr_q == rec_cnt_q - AW'(1));
  assign xfer      = (state_q == S_DUMP) && DOUT_READY;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (CLR) begin
      state_d = S_REC;
    end else begin
      case (state_q)
        S_REC:   if (DUMP_START && (cnt_after != '0)) state_d = S_DUMP;
        S_DUMP:  if (xfer && last)                    state_d = S_DONE;
        S_DONE:  if (DUMP_START)                      state_d = S_DUMP;
        default: state_d = S_REC;
      endcase
    end
  end

  assign start_dump = (state_d == S_DUMP) && (state_q != S_DUMP);

  // Word 0 is fetched on the dump-start edge, and each later word on the
  // edge that takes the previous one. If word 0 is being written on that
  // same edge, the memory still holds the old contents, so the incoming
  // sample is forwarded straight to the output instead.
  assign rd_addr = start_dump ? '0 : (rd_ptr_q + AW'(1));
  assign rd_word = mem[rd_addr[MAW-1:0]];
  assign bypass  = wr_en && (rec_cnt_q == '0);

  always_ff @(posedge CLK_ADC) begin
    if (wr_en) begin
      mem[rec_cnt_q[MAW-1:0]] <= {DATA_IN, TRGG_IN};
    end
  end

  always_ff @(posedge CLK_ADC) begin
    if (RST) begin
      state_q   <= S_REC;
      rec_cnt_q <= '0;
      trg_cnt_q <= '0;
      rd_ptr_q  <= '0;
      dout_q    <= '0;
    end else begin
      state_q <= state_d;
      if (CLR) begin
        rec_cnt_q <= '0;
        trg_cnt_q <= '0;
        rd_ptr_q  <= '0;
      end else begin
        if (wr_en) begin
          rec_cnt_q <= cnt_after;
          if (TRGG_IN && (trg_cnt_q != 16'hFFFF)) begin
            trg_cnt_q <= trg_cnt_q + 16'd1;
          end
        end
        if (start_dump) begin
          rd_ptr_q <= '0;
          dout_q   <= bypass ? {DATA_IN, TRGG_IN} : rd_word;
        end else if (xfer && !last) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
          dout_q   <= rd_word;
        end
      end
    end
  end

  assign DOUT       = dout_q[DW:1];
  assign DOUT_TRGG  = dout_q[0];
  assign DOUT_VALID = (state_q == S_DUMP);
  assign BUSY       = (state_q == S_DUMP);
  assign DOUT_LAST  = last;
  assign REC_CNT    = rec_cnt_q;
  assign TRG_CNT    = trg_cnt_q;
  assign REC_FULL   = full;
  assign DBG_STATE  = state_q;

endmodule
